// File: rtl/path_arb.sv
// Round-robin arbiter for NREQ path lanes with per-owner burst limit,
// a two-cycle flush sequence and a registered single-beat output stage.
module path_arb #(
    parameter int DWIDTH = 8,
    parameter int NREQ   = 4,
    parameter int BURST  = 4,
    localparam int OW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*DWIDTH-1:0] data_i,
    input  logic                   ready_i,
    input  logic                   flush_req_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic                   flush_o,
    output logic                   enable_o,
    output logic                   valid_o,
    output logic [DWIDTH-1:0]      data_o,
    output logic [OW-1:0]          owner_o
);

    localparam int unsigned NR = NREQ;
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]        state;
    logic [OW-1:0]     owner;
    logic [OW-1:0]     rr_pick;
    logic [OW-1:0]     idx;
    logic              rr_found;
    logic [CW-1:0]     burst_cnt;
    logic              flush_cnt;
    logic [NREQ-1:0]   gnt;
    logic              beat;
    logic              owner_req;
    logic              burst_end;
    logic [DWIDTH-1:0] lane_data;

    // Search starts one past the current owner, so a lone requester wraps back to itself.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = owner;
        idx      = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            idx = OW'((32'(owner) + i) % NR);
            if (!rr_found && req_i[idx]) begin
                rr_found = 1'b1;
                rr_pick  = idx;
            end
        end
    end

    always_comb begin
        lane_data = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (OW'(k) == owner) begin
                lane_data = data_i[k*DWIDTH +: DWIDTH];
            end
        end
    end

    assign owner_req = req_i[owner];

    always_comb begin
        gnt = '0;
        if (state == GRANT && ready_i && owner_req) begin
            gnt[owner] = 1'b1;
        end
    end

    assign beat      = |gnt;
    assign burst_end = beat && (burst_cnt == CW'(BURST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OW'(NREQ - 1);
            burst_cnt <= '0;
            flush_cnt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req_i) begin
                        state     <= FLUSH;
                        flush_cnt <= 1'b0;
                    end else if (rr_found) begin
                        owner     <= rr_pick;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // Flush wins over re-arbitration; a beat in this cycle still lands in the output stage.
                    if (flush_req_i) begin
                        state     <= FLUSH;
                        flush_cnt <= 1'b0;
                    end else if (burst_end || !owner_req) begin
                        burst_cnt <= '0;
                        if (rr_found) begin
                            owner <= rr_pick;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (beat) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                        flush_cnt <= 1'b0;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= beat;
            if (beat) begin
                data_o <= lane_data;
            end
        end
    end

    assign gnt_o    = gnt;
    assign flush_o  = (state == FLUSH);
    assign enable_o = (state != FLUSH);
    assign owner_o  = owner;

endmodule

// File: doc/path_arb.md
PATH_ARB -- requirements
Module: path_arb
Interface
REQ-001 SHALL have parameter DWIDTH, default 8, width of each lane data word.
REQ-002 SHALL have parameter NREQ, default 4, number of path lanes arbitrated.
REQ-003 SHALL have parameter BURST, default 4, maximum consecutive beats granted to one lane.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_i  input  NREQ  per-lane request, one bit from each path instance's req_o.
REQ-007 SHALL have port data_i  input  NREQ*DWIDTH  lane k data on bits [k*DWIDTH +: DWIDTH].
REQ-008 SHALL have port ready_i  input  1  downstream consumer can accept a beat this cycle.
REQ-009 SHALL have port flush_req_i  input  1  request to flush all lanes.
REQ-010 SHALL have port gnt_o  output  NREQ  one-hot-or-zero grant, drives each path's gnt_i.
REQ-011 SHALL have port flush_o  output  1  drives every path's flush_i.
REQ-012 SHALL have port enable_o  output  1  drives every path's enable_i.
REQ-013 SHALL have port valid_o  output  1  registered output beat valid.
REQ-014 SHALL have port data_o  output  DWIDTH  registered output beat data.
REQ-015 SHALL have port owner_o  output  clog2(NREQ)  current owning lane index.
Function
REQ-016 SHALL implement FSM states IDLE, GRANT, FLUSH.
REQ-017 IDLE: if any req_i bit set, owner <= round-robin pick, state <= GRANT; else stay IDLE.
REQ-018 Round-robin pick SHALL search lanes owner+1, owner+2, ... wrapping modulo NREQ, first set req_i wins.
REQ-019 gnt_o[owner] SHALL be 1 only when state==GRANT && ready_i && req_i[owner]; all other bits 0; combinational.
REQ-020 A beat transfers in any cycle where gnt_o is nonzero; burst_cnt SHALL increment on each beat.
REQ-021 GRANT, re-arbitrate at next edge when (beat && burst_cnt==BURST-1) or req_i[owner]==0: owner <= round-robin pick, burst_cnt <= 0, state stays GRANT; if no req_i set, state <= IDLE.
REQ-022 Re-arbitration after BURST beats with only the current owner requesting SHALL re-grant the same lane (wrap search returns to owner).
REQ-023 ready_i low in GRANT: gnt_o = 0, burst_cnt and owner hold, no re-arbitration unless req_i[owner]==0.
REQ-024 Latency: data_i of granted lane in cycle N SHALL appear on data_o with valid_o=1 in cycle N+1.
REQ-025 valid_o SHALL be 0 in any cycle following a cycle with gnt_o==0; data_o holds last value.
REQ-026 flush_req_i=1 in any state other than FLUSH SHALL move state to FLUSH at next edge, taking priority over arbitration and any pending beat's re-arbitration.
REQ-027 FLUSH SHALL last exactly 2 cycles: flush_o=1, enable_o=0, gnt_o=0 throughout; then state <= IDLE, burst_cnt <= 0, owner held.
REQ-028 flush_req_i asserted during FLUSH SHALL be ignored (no extension); still high on return to IDLE it SHALL start a new FLUSH.
REQ-029 A beat granted in the cycle flush_req_i rises SHALL still complete (valid_o=1 next cycle).
REQ-030 flush_o and enable_o SHALL be decoded from state: flush_o=(state==FLUSH), enable_o=(state!=FLUSH).
REQ-031 gnt_o SHALL never have more than one bit set.
Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, owner=NREQ-1, burst_cnt=0, valid_o=0, data_o=0.
REQ-033 During and after reset until first req: gnt_o=0, flush_o=0, enable_o=1, owner_o=NREQ-1.
REQ-034 Reset asserted mid-GRANT or mid-FLUSH SHALL abort the operation; first grant after release goes to lane 0 if requesting.
Verification
REQ-035 Reset then req_i=4'b0001, ready_i=1 -> cycle 1 state GRANT, gnt_o=0001 from cycle 1; data_o=lane0 data one cycle later, valid_o=1.
REQ-036 req_i=4'b1111 held, ready_i=1 -> grants 4 beats lane0, 4 beats lane1, 4 lane2, 4 lane3, then lane0; never two gnt bits set.
REQ-037 req_i=4'b0100 only, ready_i=1 for 10 cycles -> lane2 granted continuously across BURST boundary with at most zero idle grant cycles besides re-arb.
REQ-038 Lane1 owning, ready_i=0 for 3 cycles -> gnt_o=0, burst_cnt frozen, valid_o=0; resumes lane1 with remaining beats.
REQ-039 flush_req_i pulse during GRANT with req_i=4'b0011 -> flush_o=1, enable_o=0, gnt_o=0 for exactly 2 cycles, then IDLE, next grant per round-robin from held owner.
REQ-040 rst asserted mid-burst on lane3 -> outputs reach reset values same cycle; after release with req_i=4'b1001 lane0 granted first.
